// File: rtl/sys_sequencer.sv
`default_nettype none
// ============================================================================
// sys_sequencer: top-level control FSM for the CPU datapath crossbar.
// Rev 1.0 - initial release
// ============================================================================
module sys_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8,
  parameter int CNTW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            memPush,
  input  logic            aluPush,
  input  logic            decValid,
  input  logic            decIsMem,
  input  logic            decImm,
  input  logic            decHalt,
  output logic [1:0]      mode,
  output logic            immEn,
  output logic            pcAdvance,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [CNTW-1:0] retired
);

  localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC_ALU = 3'd3,
    S_EXEC_MEM = 3'd4,
    S_RETIRE   = 3'd5,
    S_HALTED   = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_wd;
  logic            r_imm;
  logic            w_imm_next;
  logic            w_waiting;
  logic [1:0]      r_mode;
  logic            r_imm_en;
  logic            r_pc_adv;
  logic            r_busy;
  logic            r_halted;
  logic            r_fault;
  logic [CNTW-1:0] r_retired;

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      S_FETCH:    mode_of = 2'd2;
      S_EXEC_ALU: mode_of = 2'd0;
      S_EXEC_MEM: mode_of = 2'd1;
      default:    mode_of = 2'd3;
    endcase
  endfunction

  always_comb begin
    w_next     = r_state;
    w_waiting  = 1'b0;
    w_imm_next = r_imm;
    case (r_state)
      S_IDLE: if (start) w_next = S_FETCH;
      S_FETCH: begin
        w_waiting = 1'b1;
        if (memPush)               w_next = S_DECODE;
        else if (r_wd == c_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        if (decValid) begin
          w_imm_next = decImm;
          if (decHalt)       w_next = S_HALTED;
          else if (decIsMem) w_next = S_EXEC_MEM;
          else               w_next = S_EXEC_ALU;
        end
      end
      S_EXEC_ALU: begin
        w_waiting = 1'b1;
        if (aluPush)                w_next = S_RETIRE;
        else if (r_wd == c_timeout) w_next = S_FAULT;
      end
      S_EXEC_MEM: begin
        w_waiting = 1'b1;
        if (memPush)                w_next = S_RETIRE;
        else if (r_wd == c_timeout) w_next = S_FAULT;
      end
      S_RETIRE: w_next = (step || !start) ? S_IDLE : S_FETCH;
      S_HALTED: w_next = S_HALTED;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wd      <= '0;
      r_imm     <= 1'b0;
      r_mode    <= 2'd3;
      r_imm_en  <= 1'b0;
      r_pc_adv  <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state  <= w_next;
      r_imm    <= w_imm_next;
      if (w_next != r_state) r_wd <= '0;
      else if (w_waiting)    r_wd <= r_wd + 1'b1;
      r_mode   <= mode_of(w_next);
      r_imm_en <= ((w_next == S_EXEC_ALU) || (w_next == S_EXEC_MEM)) && w_imm_next;
      r_pc_adv <= (w_next == S_RETIRE);
      r_busy   <= !((w_next == S_IDLE) || (w_next == S_HALTED) || (w_next == S_FAULT));
      r_halted <= (w_next == S_HALTED);
      r_fault  <= (w_next == S_FAULT);
      if (w_next == S_RETIRE) r_retired <= r_retired + 1'b1;
    end
  end

  assign mode      = r_mode;
  assign immEn     = r_imm_en;
  assign pcAdvance = r_pc_adv;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign fault     = r_fault;
  assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_sys_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sys_sequencer: randomized self-checking bench with per-instruction model.
// Rev 1.0 - initial release
// ============================================================================
module tb_sys_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CNTW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, step = 1'b0, memPush = 1'b0, aluPush = 1'b0;
  logic decValid = 1'b0, decIsMem = 1'b0, decImm = 1'b0, decHalt = 1'b0;
  logic [1:0]      mode;
  logic            immEn, pcAdvance, busy, halted, fault;
  logic [CNTW-1:0] retired;

  sys_sequencer #(.TIMEOUT(TIMEOUT), .TW(8), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .memPush(memPush), .aluPush(aluPush), .decValid(decValid),
    .decIsMem(decIsMem), .decImm(decImm), .decHalt(decHalt),
    .mode(mode), .immEn(immEn), .pcAdvance(pcAdvance), .busy(busy),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, start, step, mem, alu, dv, dmem, dimm, dhalt;
  } stim_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic            imm, pc, busy, halted, fault;
    logic [CNTW-1:0] ret;
  } obs_t;

  stim_t sq[$];
  obs_t  eq[$];
  obs_t  oq[$];
  bit    ec[$];

  int vectors = 0;
  int miscompares = 0;
  logic [CNTW-1:0] m_ret = '0;
  int m_end = 0;  // 0 retired, 1 halted, 2 faulted, 3 reset-aborted

  function automatic stim_t rnd();
    logic [31:0] r;
    stim_t s;
    r = $urandom;
    s = r[8:0];
    s.rst = 1'b0;
    return s;
  endfunction

  function automatic obs_t mk(logic [1:0] m, logic im, logic pc, logic bz, logic h, logic f);
    obs_t o;
    o = '{mode: m, imm: im, pc: pc, busy: bz, halted: h, fault: f, ret: m_ret};
    return o;
  endfunction

  task automatic push(stim_t s, obs_t e, bit c);
    sq.push_back(s); eq.push_back(e); ec.push_back(c);
  endtask

  task automatic clear_q();
    sq.delete(); eq.delete(); oq.delete(); ec.delete();
  endtask

  task automatic add_rst();
    stim_t s = '0;
    s.rst = 1'b1;
    push(s, '0, 1'b0);
    m_ret = '0;
  endtask

  task automatic add_idle(bit st);
    stim_t s = rnd();
    s.start = st;
    push(s, mk(2'd3, 0, 0, 0, 0, 0), 1'b1);
  endtask

  task automatic add_sticky(int n, bit is_fault);
    for (int i = 0; i < n; i++) push(rnd(), mk(2'd3, 0, 0, 0, !is_fault, is_fault), 1'b1);
  endtask

  // One instruction starting in FETCH: push after f/d/e wait cycles of each phase.
  task automatic add_instr(int f, int d, int e, bit ismem, bit imm, bit halt,
                           bit st, bit stp, int abort = -1);
    stim_t s;
    logic [1:0] m;
    for (int i = 0; i <= f && i <= TIMEOUT; i++) begin
      s = rnd(); s.mem = (i == f);
      push(s, mk(2'd2, 0, 0, 1, 0, 0), 1'b1);
    end
    if (f > TIMEOUT) begin m_end = 2; return; end
    for (int i = 0; i <= d; i++) begin
      s = rnd(); s.dv = (i == d);
      if (i == d) begin s.dmem = ismem; s.dimm = imm; s.dhalt = halt; end
      push(s, mk(2'd3, 0, 0, 1, 0, 0), 1'b1);
    end
    if (halt) begin m_end = 1; return; end
    m = ismem ? 2'd1 : 2'd0;
    for (int i = 0; i <= e && i <= TIMEOUT; i++) begin
      s = rnd();
      if (ismem) s.mem = (i == e); else s.alu = (i == e);
      if (i == abort) begin
        s.rst = 1'b1; s.alu = 1'b1;
        push(s, mk(m, imm, 0, 1, 0, 0), 1'b1);
        m_ret = '0; m_end = 3;
        return;
      end
      push(s, mk(m, imm, 0, 1, 0, 0), 1'b1);
    end
    if (e > TIMEOUT) begin m_end = 2; return; end
    m_ret = m_ret + 1'b1;
    s = rnd(); s.start = st; s.step = stp;
    push(s, mk(2'd3, 0, 1, 1, 0, 0), 1'b1);
    m_end = 0;
  endtask

  task automatic apply();
    obs_t o;
    foreach (sq[i]) begin
      @(negedge clk);
      o = '{mode: mode, imm: immEn, pc: pcAdvance, busy: busy,
            halted: halted, fault: fault, ret: retired};
      oq.push_back(o);
      {rst, start, step, memPush, aluPush, decValid, decIsMem, decImm, decHalt} = sq[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; memPush = 1'b1; aluPush = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (mode !== 2'd3) begin miscompares++; $display("FAIL reset_mode got %0d expected 3", mode); end
    vectors++; if (immEn !== 1'b0) begin miscompares++; $display("FAIL reset_immEn got %b expected 0", immEn); end
    vectors++; if (pcAdvance !== 1'b0) begin miscompares++; $display("FAIL reset_pcAdvance got %b expected 0", pcAdvance); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b expected 0", halted); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b expected 0", fault); end
    vectors++; if (retired !== '0) begin miscompares++; $display("FAIL reset_retired got %0d expected 0", retired); end
  endtask

  task automatic test_alu_path();
    clear_q(); add_rst(); add_idle(1);
    add_instr(0, 0, 0, 0, 1, 0, 1, 0);
    add_instr(2, 1, 3, 0, 0, 0, 0, 0);
    add_idle(0); add_idle(0);
    apply();
    foreach (eq[i]) if (ec[i]) begin
      vectors++;
      if (oq[i] !== eq[i]) begin miscompares++; $display("FAIL alu_path cycle %0d got %h expected %h", i, oq[i], eq[i]); end
    end
  endtask

  task automatic test_mem_path();
    clear_q(); add_rst(); add_idle(1);
    add_instr(1, 0, 3, 1, 0, 0, 1, 0);
    add_instr(0, 2, 0, 1, 1, 0, 0, 0);
    add_idle(0);
    apply();
    foreach (eq[i]) if (ec[i]) begin
      vectors++;
      if (oq[i] !== eq[i]) begin miscompares++; $display("FAIL mem_path cycle %0d got %h expected %h", i, oq[i], eq[i]); end
    end
  endtask

  task automatic test_watchdog();
    clear_q(); add_rst(); add_idle(1);
    add_instr(TIMEOUT + 1, 0, 0, 0, 0, 0, 1, 0);
    add_sticky(6, 1);
    add_rst(); add_idle(1);
    add_instr(TIMEOUT, 0, TIMEOUT, 1, 1, 0, 1, 0);
    add_instr(0, 0, TIMEOUT + 1, 0, 1, 0, 1, 0);
    add_sticky(4, 1);
    apply();
    foreach (eq[i]) if (ec[i]) begin
      vectors++;
      if (oq[i] !== eq[i]) begin miscompares++; $display("FAIL watchdog cycle %0d got %h expected %h", i, oq[i], eq[i]); end
    end
  endtask

  task automatic test_halt();
    clear_q(); add_rst(); add_idle(1);
    add_instr(0, 0, 1, 0, 0, 0, 1, 0);
    add_instr(1, 2, 0, 0, 1, 1, 1, 0);
    add_sticky(8, 0);
    apply();
    foreach (eq[i]) if (ec[i]) begin
      vectors++;
      if (oq[i] !== eq[i]) begin miscompares++; $display("FAIL halt cycle %0d got %h expected %h", i, oq[i], eq[i]); end
    end
  endtask

  task automatic test_single_step();
    clear_q(); add_rst(); add_idle(1);
    for (int n = 0; n < 2**CNTW + 2; n++) begin
      add_instr(int'($urandom_range(0, 1)), 0, int'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1, 1);
      add_idle(1);
    end
    apply();
    foreach (eq[i]) if (ec[i]) begin
      vectors++;
      if (oq[i] !== eq[i]) begin miscompares++; $display("FAIL single_step cycle %0d got %h expected %h", i, oq[i], eq[i]); end
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_q(); add_rst(); add_idle(1);
    add_instr(0, 0, 3, 0, 1, 0, 1, 0, 1);
    add_idle(0); add_idle(0);
    apply();
    foreach (eq[i]) if (ec[i]) begin
      vectors++;
      if (oq[i] !== eq[i]) begin miscompares++; $display("FAIL reset_mid_exec cycle %0d got %h expected %h", i, oq[i], eq[i]); end
    end
  endtask

  task automatic test_random();
    bit st, stp;
    int f, e;
    clear_q(); add_rst(); add_idle(1);
    for (int n = 0; n < 60; n++) begin
      f   = ($urandom_range(0, 15) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, TIMEOUT));
      e   = ($urandom_range(0, 15) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, TIMEOUT));
      st  = ($urandom_range(0, 3) != 0);
      stp = ($urandom_range(0, 3) == 0);
      add_instr(f, int'($urandom_range(0, 3)), e, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), st, stp);
      if (m_end == 1 || m_end == 2) begin
        add_sticky(3, m_end == 2);
        add_rst(); add_idle(1);
      end else if (!st || stp) begin
        add_idle(1);
      end
    end
    apply();
    foreach (eq[i]) if (ec[i]) begin
      vectors++;
      if (oq[i] !== eq[i]) begin miscompares++; $display("FAIL random cycle %0d got %h expected %h", i, oq[i], eq[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_path();
    test_mem_path();
    test_watchdog();
    test_halt();
    test_single_step();
    test_reset_mid_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
